msp430_spram_arbiter: RTL and testbench
=======================================

Name: msp430_spram_arbiter

Overview:
- Shares one single-port synchronous RAM (msp430_ram style) between NODES requesters in the msp430_mpsoc3d tile array.
- Performs at most one access per cycle. Arbitration is round-robin.
- A requester may lock the grant for a bounded number of cycles, for read-modify-write sequences.
- Sits between the per-node bb_ext_* memory ports and a shared RAM instance.

Parameters:
- NODES, 8, number of requesters (≥2).
- AW, 32, address width.
- DW, 32, data width.
- MAX_LOCK, 4, maximum consecutive cycles a locked owner keeps the grant (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_i  in  NODES  access request, one bit per requester.
- lock_i  in  NODES  request to retain the grant after the current access.
- addr_i  in  NODES×AW  request address.
- din_i  in  NODES×DW  write data.
- we_i  in  NODES  1 = write, 0 = read.
- gnt_o  out  NODES  one-hot; the access is taken this cycle.
- rvalid_o  out  NODES  one-hot; read data valid on rdata_o.
- rdata_o  out  DW  read data, shared by all requesters.
- ram_addr_o  out  AW  shared RAM address.
- ram_din_o  out  DW  shared RAM write data.
- ram_cen_o  out  1  RAM chip enable, active-low.
- ram_wen_o  out  1  RAM write enable, active-low.
- ram_dout_i  in  DW  RAM read data, valid one cycle after the access.

Behaviour:
- Reset (rst=0, asynchronous): ptr=0, owner invalid, lock_cnt=0, rvalid_o=0. While reset is asserted: gnt_o=0, ram_cen_o=1, ram_wen_o=1, ram_addr_o=0, ram_din_o=0.
- Handshake:
  - Requester holds req/addr/din/we stable until gnt_o=1.
  - gnt_o is combinational from req_i and the registered state; the access completes in the grant cycle.
  - Dropping req before grant is allowed, with no side effect.
- State machine, two states:
  - ARB: winner = first requester with req=1, searching from ptr upward with wrap-around (NODES-1 → 0). No req → gnt_o=0, ram_cen_o=1.
  - LOCKED: owner has priority. If owner req=1, it is granted regardless of the others. If owner req=0, fall through to ARB search in the same cycle.
- Transitions, evaluated at the grant edge for winner w:
  - ptr ← (w+1) mod NODES on every grant, whether in ARB or LOCKED.
  - lock_i[w]=1 and lock_cnt+1 < MAX_LOCK → LOCKED, owner=w, lock_cnt++.
  - Otherwise → ARB, lock_cnt=0.
- Leaving LOCKED:
  - Owner deasserts lock_i with a grant → ARB next cycle.
  - Owner idle (req=0) for one cycle → lock released: ARB, lock_cnt=0.
  - After MAX_LOCK consecutive owner grants, the lock is forcibly released; the next search starts at owner+1.
- RAM drive: ram_addr_o=addr_i[w], ram_din_o=din_i[w], ram_cen_o=0, ram_wen_o=~we_i[w] in the grant cycle.
- Read return: rvalid_o[w] is registered one cycle after a read grant. rdata_o=ram_dout_i unregistered, so total read latency is 1 cycle. Writes produce no rvalid.
- Back-to-back: a new grant and a previous rvalid may coincide, including for the same requester. One access per cycle; full throughput.
- Fairness: with MAX_LOCK cycles of locking, any continuously requesting node waits at most (NODES-1)×MAX_LOCK cycles.
- Reset mid-lock: state is cleared and the in-flight rvalid is dropped.
- NODES not a power of two: ptr wraps explicitly and never holds an index ≥ NODES.

Decomposition:
- Package msp430_spram_arb_pkg holds:
  - localparam IDX_W = $clog2(NODES);
  - typedef enum {ARB, LOCKED} arb_state_t;
  - function rr_pick(req, ptr), returning index plus a found flag.
- Sub-module msp430_rr_arbiter: combinational rotating-priority picker, inputs req/ptr, outputs one-hot grant and index. Reused by the lock-override logic.

Test Plan:
- Reset with req_i=8'hFF held → gnt_o=0, ram_cen_o=1 during reset. First cycle after release: gnt_o=8'h01, then 02, 04, … 80, 01 on consecutive cycles.
- Node 3 writes 0xDEADBEEF to addr 0x10, then reads 0x10 → write grant with ram_wen_o=0. Read grant next; one cycle later rvalid_o=8'h08, rdata_o=0xDEADBEEF.
- Nodes 2 and 5 request continuously; node 2 holds lock_i, MAX_LOCK=4 → node 2 granted 4 consecutive cycles, then node 5, then node 2 again.
- Owner 2 locked, drops req for one cycle while node 6 requests → node 6 granted that cycle; lock released (state ARB, lock_cnt=0).
- Reset asserted mid-lock, in the cycle after a read grant → rvalid_o stays 0. After release, ptr=0 and node 0 wins over node 7.
- Random req/we/lock over 10k cycles against a reference model → data matches, gnt_o one-hot or zero, and no node waits > (NODES-1)×MAX_LOCK cycles.

Source files
------------

// File: rtl/msp430_spram_arb_pkg.sv
// Shared types and the rotating-priority search used by the shared-RAM arbiter.
package msp430_spram_arb_pkg;

  // Upper bound on requesters; the search function works on this width.
  localparam int unsigned MAX_NODES = 32;
  localparam int unsigned IDX_W     = $clog2(MAX_NODES);

  typedef enum logic {ARB, LOCKED} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or above ptr, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_NODES-1:0] req,
                                       input logic [IDX_W-1:0]     ptr,
                                       input int unsigned          n);
    rr_pick_t    r;
    int unsigned i;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned k = 0; k < MAX_NODES; k++) begin
      if (k < n) begin
        i = 32'(ptr) + k;
        if (i >= n) i = i - n;
        if (!r.found && req[i[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = i[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/msp430_rr_arbiter.sv
// Combinational rotating-priority picker: one-hot grant and index of the winner.
module msp430_rr_arbiter
  import msp430_spram_arb_pkg::*;
#(
  parameter int unsigned NODES = 8,
  parameter int unsigned IdxW  = $clog2(NODES)
) (
  input  logic [NODES-1:0] i_req,
  input  logic [IdxW-1:0]  i_ptr,
  output logic [NODES-1:0] o_gnt,
  output logic [IdxW-1:0]  o_idx,
  output logic             o_found
);

  rr_pick_t w_pick;

  always_comb begin
    w_pick  = rr_pick(MAX_NODES'(i_req), IDX_W'(i_ptr), NODES);
    o_found = w_pick.found;
    o_idx   = IdxW'(w_pick.idx);
    o_gnt   = '0;
    if (w_pick.found) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/msp430_spram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between NODES
// requesters, with a bounded grant lock for read-modify-write sequences.
module msp430_spram_arbiter
  import msp430_spram_arb_pkg::*;
#(
  parameter int unsigned NODES    = 8,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NODES-1:0]    req_i,
  input  logic [NODES-1:0]    lock_i,
  input  logic [NODES*AW-1:0] addr_i,
  input  logic [NODES*DW-1:0] din_i,
  input  logic [NODES-1:0]    we_i,
  output logic [NODES-1:0]    gnt_o,
  output logic [NODES-1:0]    rvalid_o,
  output logic [DW-1:0]       rdata_o,
  output logic [AW-1:0]       ram_addr_o,
  output logic [DW-1:0]       ram_din_o,
  output logic                ram_cen_o,
  output logic                ram_wen_o,
  input  logic [DW-1:0]       ram_dout_i
);

  localparam int unsigned IdxW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

  arb_state_t       r_state, w_state_d;
  logic [IdxW-1:0]  r_ptr, w_ptr_d;
  logic [NODES-1:0] r_owner_oh, w_owner_oh_d;
  logic [CntW-1:0]  r_lock_cnt, w_cnt_d, w_cnt_base;
  logic [NODES-1:0] r_rvalid;

  logic [NODES-1:0] w_rr_gnt, w_own_gnt, w_win_oh;
  logic [IdxW-1:0]  w_rr_idx, w_own_idx, w_win;
  logic             w_rr_found, w_own_found, w_owner_hit, w_take, w_we, w_lock;

  msp430_rr_arbiter #(.NODES(NODES), .IdxW(IdxW)) u_rr (
    .i_req   (req_i),
    .i_ptr   (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_found (w_rr_found)
  );

  // Same picker restricted to the lock owner's bit yields the override grant.
  msp430_rr_arbiter #(.NODES(NODES), .IdxW(IdxW)) u_owner (
    .i_req   (req_i & r_owner_oh),
    .i_ptr   ('0),
    .o_gnt   (w_own_gnt),
    .o_idx   (w_own_idx),
    .o_found (w_own_found)
  );

  always_comb begin
    w_owner_hit = (r_state == LOCKED) && w_own_found;
    w_take      = (w_owner_hit || w_rr_found) && rst;
    w_win       = w_owner_hit ? w_own_idx : w_rr_idx;
    w_win_oh    = w_owner_hit ? w_own_gnt : w_rr_gnt;
    w_cnt_base  = w_owner_hit ? r_lock_cnt : '0;
    w_we        = w_take && |(we_i & w_win_oh);
    w_lock      = w_take && |(lock_i & w_win_oh);

    gnt_o      = w_take ? w_win_oh : '0;
    ram_cen_o  = ~w_take;
    ram_wen_o  = ~w_we;
    ram_addr_o = '0;
    ram_din_o  = '0;
    for (int i = 0; i < int'(NODES); i++) begin
      if (w_take && w_win_oh[i]) begin
        ram_addr_o = addr_i[i*AW +: AW];
        ram_din_o  = din_i[i*DW +: DW];
      end
    end

    // No grant (idle owner or no requests) always drops back to ARB.
    w_state_d    = ARB;
    w_cnt_d      = '0;
    w_owner_oh_d = r_owner_oh;
    w_ptr_d      = r_ptr;
    if (w_take) begin
      w_ptr_d = (w_win == IdxW'(NODES - 1)) ? '0 : w_win + IdxW'(1);
      if (w_lock && (32'(w_cnt_base) + 32'd1 < MAX_LOCK)) begin
        w_state_d    = LOCKED;
        w_owner_oh_d = w_win_oh;
        w_cnt_d      = w_cnt_base + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_owner_oh <= '0;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state    <= w_state_d;
      r_ptr      <= w_ptr_d;
      r_owner_oh <= w_owner_oh_d;
      r_lock_cnt <= w_cnt_d;
      r_rvalid   <= (w_take && !w_we) ? w_win_oh : '0;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = ram_dout_i;

endmodule

// File: tb/tb_msp430_spram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model of the round-robin/lock rules and a scoreboard memory.
module tb_msp430_spram_arbiter;

  localparam int NODES    = 8;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_LOCK = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NODES-1:0]    req = '0, lock = '0, we = '0;
  logic [NODES*AW-1:0] addr = '0;
  logic [NODES*DW-1:0] din = '0;
  logic [NODES-1:0]    gnt, rvalid;
  logic [DW-1:0]       rdata, ram_din;
  logic [DW-1:0]       ram_dout = '0;
  logic [AW-1:0]       ram_addr;
  logic                ram_cen, ram_wen;

  always #5 clk = ~clk;

  msp430_spram_arbiter #(.NODES(NODES), .AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .lock_i     (lock),
    .addr_i     (addr),
    .din_i      (din),
    .we_i       (we),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_cen_o  (ram_cen),
    .ram_wen_o  (ram_wen),
    .ram_dout_i (ram_dout)
  );

  // Environment RAM driven by the DUT.
  logic [DW-1:0] ram_mem [256] = '{default: '0};
  always @(posedge clk) begin
    if (!ram_cen) begin
      if (!ram_wen) ram_mem[ram_addr[7:0]] <= ram_din;
      else          ram_dout <= ram_mem[ram_addr[7:0]];
    end
  end

  // Reference model state.
  logic [DW-1:0]    ref_mem [256] = '{default: '0};
  int               m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit               m_locked = 0;
  logic [NODES-1:0] m_rvalid = '0, m_last_gnt = '0;
  logic [DW-1:0]    m_rdata = '0;
  int               wait_c [NODES];
  int               max_wait = 0;
  int               n_checks = 0, n_pass = 0;
  logic [NODES-1:0] pend = '0;
  logic [7:0]       lock_seq [10] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h20,
                                      8'h04, 8'h04, 8'h04, 8'h04, 8'h20};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
    m_rvalid = '0; m_last_gnt = '0;
    for (int i = 0; i < NODES; i++) wait_c[i] = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    lock = '0;
    pend = '0;
    model_reset();
    next_cycle();
    rst = 1'b1;
  endtask

  // Called at posedge+1 with inputs applied; compares mid-cycle, then advances the model.
  task automatic step();
    int               w;
    int               base;
    bit               found, own_hit;
    logic [AW-1:0]    a;
    logic [NODES-1:0] e_gnt;
    #3;
    own_hit = m_locked && req[m_owner];
    found   = own_hit;
    w       = m_owner;
    if (!own_hit) begin
      for (int k = 0; k < NODES; k++) begin
        if (!found && req[(m_ptr + k) % NODES]) begin
          found = 1;
          w     = (m_ptr + k) % NODES;
        end
      end
    end
    e_gnt = '0;
    if (found) e_gnt[w] = 1'b1;
    check_eq("gnt", gnt, e_gnt);
    check_eq("cen", ram_cen, !found);
    check_eq("rvalid", rvalid, m_rvalid);
    if (m_rvalid != '0) check_eq("rdata", rdata, m_rdata);
    a = addr[w*AW +: AW];
    if (found) begin
      check_eq("addr", ram_addr, a);
      check_eq("wen", ram_wen, !we[w]);
      if (we[w]) check_eq("din", ram_din, din[w*DW +: DW]);
    end
    for (int i = 0; i < NODES; i++) begin
      if (req[i] && !e_gnt[i]) wait_c[i]++;
      else wait_c[i] = 0;
      if (wait_c[i] > max_wait) max_wait = wait_c[i];
    end
    m_rvalid = '0;
    if (found) begin
      if (we[w]) ref_mem[a[7:0]] = din[w*DW +: DW];
      else begin
        m_rvalid[w] = 1'b1;
        m_rdata     = ref_mem[a[7:0]];
      end
      base  = own_hit ? m_cnt : 0;
      m_ptr = (w + 1) % NODES;
      if (lock[w] && base + 1 < MAX_LOCK) begin
        m_locked = 1; m_owner = w; m_cnt = base + 1;
      end else begin
        m_locked = 0; m_cnt = 0;
      end
    end else begin
      m_locked = 0; m_cnt = 0;
    end
    m_last_gnt = e_gnt;
  endtask

  initial begin
    model_reset();
    // Reset with every node requesting: nothing may reach the RAM.
    req = '1;
    for (int i = 0; i < NODES; i++) addr[i*AW +: AW] = AW'(i);
    #13;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_cen", ram_cen, 1);
    check_eq("rst_wen", ram_wen, 1);
    check_eq("rst_addr", ram_addr, 0);
    check_eq("rst_din", ram_din, 0);
    check_eq("rst_rvalid", rvalid, 0);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      check_eq("rr_seq", gnt, 64'(1) << (k % NODES));
      next_cycle();
    end

    // Node 3 writes then reads back 0x10.
    do_reset();
    req = 8'h08; we = 8'h08;
    addr[3*AW +: AW] = 32'h10;
    din[3*DW +: DW]  = 32'hDEADBEEF;
    step();
    check_eq("wr_wen", ram_wen, 0);
    next_cycle();
    we = '0;
    step();
    check_eq("rd_wen", ram_wen, 1);
    next_cycle();
    req = '0;
    step();
    check_eq("rd_rvalid", rvalid, 8'h08);
    check_eq("rd_data", rdata, 32'hDEADBEEF);
    next_cycle();

    // Node 2 holds a lock against node 5.
    do_reset();
    req = 8'h24; lock = 8'h04; we = 8'h24;
    for (int k = 0; k < 10; k++) begin
      step();
      check_eq("lock_seq", gnt, lock_seq[k]);
      next_cycle();
    end

    // Locked owner goes idle for one cycle: lock released.
    do_reset();
    req = 8'h04; lock = 8'h04; we = 8'h04;
    step();
    check_eq("idle_lock0", gnt, 8'h04);
    next_cycle();
    req = 8'h40; we = 8'h40; lock = 8'h04;
    step();
    check_eq("idle_n6", gnt, 8'h40);
    next_cycle();
    req = 8'h06; we = 8'h06; lock = '0;
    step();
    check_eq("idle_released", gnt, 8'h02);
    next_cycle();

    // Reset asserted mid-lock, right after a read grant.
    do_reset();
    req = 8'h84; lock = 8'h04; we = '0;
    step();
    check_eq("ml_gnt", gnt, 8'h04);
    next_cycle();
    rst = 1'b0;
    model_reset();
    #2;
    check_eq("ml_rvalid", rvalid, 0);
    check_eq("ml_gnt_rst", gnt, 0);
    next_cycle();
    rst = 1'b1;
    req = 8'h81; lock = '0;
    step();
    check_eq("ml_ptr0", gnt, 8'h01);
    next_cycle();

    // Randomized traffic; requesters hold their request until granted.
    do_reset();
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NODES; i++) begin
        if (pend[i] && m_last_gnt[i]) pend[i] = 1'b0;
        if (pend[i] && $urandom_range(63) == 0) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(1) == 1) begin
          pend[i]          = 1'b1;
          addr[i*AW +: AW] = AW'($urandom_range(31));
          din[i*DW +: DW]  = $urandom;
          we[i]            = 1'($urandom_range(1));
        end
        lock[i] = ($urandom_range(2) != 0);
      end
      req = pend;
      step();
      next_cycle();
    end
    check_eq("fair_wait", 64'(max_wait <= (NODES - 1) * MAX_LOCK), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
